regfile_writeback: RTL

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

---
 rtl/regfile_writeback.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - register-file writeback arbiter with 4-entry write queue
//
// Purpose: accepts writeback requests from a load unit (mem, priority) and an
// ALU, queues them in order in a 4-entry FIFO and drains one write per cycle
// onto the register-file write port. Writes to x0 are acknowledged and dropped.
//
// Configuration macro: REGFILE_CLEAR_EN
//   defined   -> after reset a 32-cycle sweep writes zero to every register
//                (state CLEAR) before requests are accepted (state RUN).
//   undefined -> no sweep; the block is in RUN directly out of reset.
//
// Ports:
//   CLK, RESET                   clock, synchronous active-high reset
//   alu_valid/alu_rd/alu_data    ALU writeback request; alu_ready = accepted
//   mem_valid/mem_rd/mem_data    load writeback request; mem_ready = accepted
//   WE3, A3, WD3                 register-file write port
//   q_addr, q_pending            hazard query: a queued write targets q_addr
//   busy                         clearing or queue non-empty

module regfile_writeback (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    input  logic [4:0]  q_addr,
    output logic        q_pending,
    output logic        busy
);

    logic [4:0]  rd_q   [4];
    logic [31:0] data_q [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;

    logic        run;
    logic        clearing;
    logic        space;
    logic        accept_mem;
    logic        accept_alu;
    logic        enq;
    logic        deq;
    logic [4:0]  enq_rd;
    logic [31:0] enq_data;

`ifdef REGFILE_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t     state_q, state_d;
    logic [4:0] clr_cnt_q, clr_cnt_d;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_CLEAR;
            clr_cnt_q <= 5'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Sweep one register per cycle; leave CLEAR right after writing x31.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == S_CLEAR) begin
            clr_cnt_d = clr_cnt_q + 5'd1;
            if (clr_cnt_q == 5'd31) begin
                state_d = S_RUN;
            end
        end
    end

    assign run      = (state_q == S_RUN);
    assign clearing = (state_q == S_CLEAR);
`else
    assign run      = 1'b1;
    assign clearing = 1'b0;
`endif

    // Full check uses the registered count: a same-cycle pop does not free a slot.
    assign space      = (count_q < 3'd4);
    assign mem_ready  = run && space;
    assign alu_ready  = run && space && !mem_valid;
    assign accept_mem = mem_valid && mem_ready;
    assign accept_alu = alu_valid && alu_ready;
    assign enq_rd     = accept_mem ? mem_rd   : alu_rd;
    assign enq_data   = accept_mem ? mem_data : alu_data;
    // x0 requests complete the handshake but never enter the queue.
    assign enq        = (accept_mem || accept_alu) && (enq_rd != 5'd0);
    assign deq        = run && (count_q != 3'd0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + 2'd1;
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        count_d = count_q + {2'b00, enq} - {2'b00, deq};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage carries no reset; validity is tracked by count/pointers.
    always_ff @(posedge CLK) begin
        if (!RESET && enq) begin
            rd_q[wr_ptr_q]   <= enq_rd;
            data_q[wr_ptr_q] <= enq_data;
        end
    end

    always_comb begin
        WE3 = 1'b0;
        A3  = 5'd0;
        WD3 = 32'd0;
`ifdef REGFILE_CLEAR_EN
        if (state_q == S_CLEAR) begin
            WE3 = 1'b1;
            A3  = clr_cnt_q;
        end else
`endif
        if (count_q != 3'd0) begin
            WE3 = 1'b1;
            A3  = rd_q[rd_ptr_q];
            WD3 = data_q[rd_ptr_q];
        end
    end

    // An entry is live when its distance from the head is below the count.
    always_comb begin
        logic [1:0] off;
        q_pending = 1'b0;
        for (int i = 0; i < 4; i++) begin
            off = 2'(i) - rd_ptr_q;
            if (({1'b0, off} < count_q) && (rd_q[i] == q_addr) && (q_addr != 5'd0)) begin
                q_pending = 1'b1;
            end
        end
    end

    assign busy = clearing || (count_q != 3'd0);

endmodule
